// File: rtl/btn_seq_ctrl_pkg.sv
// Shared types and constants for the three-button sequencer.
package btn_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EDIT = 2'd1,
    RUN  = 2'd2
  } state_e;

  localparam int B_SEL = 0;
  localparam int B_UP  = 1;
  localparam int B_RUN = 2;
  localparam int BCD_W = 4;

  function automatic logic [BCD_W-1:0] bcd_digit_inc(input logic [BCD_W-1:0] d);
    return (d == 4'd9) ? 4'd0 : d + 4'd1;
  endfunction

endpackage

// File: rtl/btn_seq_ctrl_tick_gen.sv
// Free-running divider: one-cycle TICK every DIV cycles, CLR restarts the period.
module tick_gen #(
  parameter int DIV = 2
) (
  input  logic CLK,
  input  logic nRST,
  input  logic CLR,
  output logic TICK
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt_q;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      cnt_q <= '0;
    end else if (CLR || (cnt_q == LAST)) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + W'(1);
    end
  end

  assign TICK = (cnt_q == LAST);

endmodule

// File: rtl/btn_seq_ctrl.sv
// Button-driven 4-digit BCD sequencer: hold, digit edit with blinking cursor, free count.
module btn_seq_ctrl #(
  parameter int CLK_HZ   = 50_000_000,
  parameter int TICK_HZ  = 10,
  parameter int BLINK_HZ = 2
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic [2:0]  BIN,
  output logic [15:0] VALUE,
  output logic [3:0]  BLANK,
  output logic [1:0]  EDIT_DIG,
  output logic        RUNNING
);
  import btn_seq_pkg::*;

  localparam int TP = CLK_HZ / TICK_HZ;
  localparam int HP = CLK_HZ / (2 * BLINK_HZ);

  state_e      state_q, state_d;
  logic [15:0] value_d;
  logic [1:0]  dig_d;
  logic [3:0]  blank_d;
  logic        phase_q, phase_d;
  logic        do_run, do_sel, do_up;
  logic        tclr, bclr, ttick, btick;

  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        carry;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        carry = (v[i*BCD_W +: BCD_W] == 4'd9);
        r[i*BCD_W +: BCD_W] = bcd_digit_inc(v[i*BCD_W +: BCD_W]);
      end
    end
    return r;
  endfunction

  // RUN outranks SEL outranks UP; losers in the same cycle are dropped.
  assign do_run = BIN[B_RUN];
  assign do_sel = BIN[B_SEL] && !do_run;
  assign do_up  = BIN[B_UP] && !do_run && !do_sel;

  tick_gen #(.DIV(TP)) u_count_tick (
    .CLK  (CLK),
    .nRST (nRST),
    .CLR  (tclr),
    .TICK (ttick)
  );

  tick_gen #(.DIV(HP)) u_blink_tick (
    .CLK  (CLK),
    .nRST (nRST),
    .CLR  (bclr),
    .TICK (btick)
  );

  always_comb begin
    state_d = state_q;
    value_d = VALUE;
    dig_d   = EDIT_DIG;
    case (state_q)
      IDLE: begin
        if (do_run) begin
          state_d = RUN;
        end else if (do_sel) begin
          state_d = EDIT;
          dig_d   = 2'd0;
        end else if (do_up) begin
          value_d = '0;
        end
      end
      EDIT: begin
        if (do_run) begin
          state_d = RUN;
          dig_d   = 2'd0;
        end else if (do_sel) begin
          if (EDIT_DIG == 2'd3) begin
            state_d = IDLE;
            dig_d   = 2'd0;
          end else begin
            dig_d = EDIT_DIG + 2'd1;
          end
        end else if (do_up) begin
          value_d[{EDIT_DIG, 2'b00} +: BCD_W] = bcd_digit_inc(VALUE[{EDIT_DIG, 2'b00} +: BCD_W]);
        end
      end
      RUN: begin
        if (do_run) begin
          state_d = IDLE;
        end else if (ttick) begin
          value_d = bcd_inc(VALUE);
        end
      end
      default: begin
        state_d = IDLE;
        dig_d   = 2'd0;
      end
    endcase

    // Dividers sit at zero unless their mode is active and continuing.
    tclr    = (state_q != RUN) || (state_d != RUN);
    bclr    = (state_q != EDIT) || (state_d != EDIT) || do_sel;
    phase_d = bclr ? 1'b0 : (btick ? ~phase_q : phase_q);
    blank_d = ((state_d == EDIT) && phase_d) ? (4'b0001 << dig_d) : 4'b0000;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q  <= IDLE;
      VALUE    <= '0;
      BLANK    <= '0;
      EDIT_DIG <= '0;
      RUNNING  <= 1'b0;
      phase_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      VALUE    <= value_d;
      BLANK    <= blank_d;
      EDIT_DIG <= dig_d;
      RUNNING  <= (state_d == RUN);
      phase_q  <= phase_d;
    end
  end

endmodule

// File: tb/tb_btn_seq_ctrl.sv
// Bench for btn_seq_ctrl: directed table, hand-written corner sequences, random run vs model.
module tb_btn_seq_ctrl;

  localparam int CLK_HZ   = 100;
  localparam int TICK_HZ  = 10;
  localparam int BLINK_HZ = 5;
  localparam int TP       = CLK_HZ / TICK_HZ;
  localparam int HP       = CLK_HZ / (2 * BLINK_HZ);

  logic        CLK = 1'b0;
  logic        nRST;
  logic [2:0]  BIN;
  logic [15:0] VALUE;
  logic [3:0]  BLANK;
  logic [1:0]  EDIT_DIG;
  logic        RUNNING;

  btn_seq_ctrl #(
    .CLK_HZ   (CLK_HZ),
    .TICK_HZ  (TICK_HZ),
    .BLINK_HZ (BLINK_HZ)
  ) dut (
    .CLK      (CLK),
    .nRST     (nRST),
    .BIN      (BIN),
    .VALUE    (VALUE),
    .BLANK    (BLANK),
    .EDIT_DIG (EDIT_DIG),
    .RUNNING  (RUNNING)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  // Reference model: mode 0 idle, 1 edit, 2 run; value kept as a decimal integer.
  int m_mode, m_val, m_dig, m_age, m_bage;

  typedef struct {
    logic [2:0]  bin;
    logic [15:0] value;
    logic [3:0]  blank;
    logic [1:0]  dig;
    logic        run;
  } vec_t;
  vec_t tbl[20];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int pw10(input int i);
    int r = 1;
    for (int k = 0; k < i; k++) r = r * 10;
    return r;
  endfunction

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    for (int i = 0; i < 4; i++) r[i*4 +: 4] = 4'((v / pw10(i)) % 10);
    return r;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_val = 0; m_dig = 0; m_age = 0; m_bage = 0;
  endtask

  task automatic model_step(input logic [2:0] b);
    bit run, sel, up;
    int d;
    run = b[2];
    sel = b[0] && !run;
    up  = b[1] && !run && !sel;
    case (m_mode)
      0: begin
        if (run) begin m_mode = 2; m_age = 0; end
        else if (sel) begin m_mode = 1; m_dig = 0; m_bage = 0; end
        else if (up) m_val = 0;
      end
      1: begin
        if (run) begin m_mode = 2; m_age = 0; m_dig = 0; end
        else if (sel) begin
          m_bage = 0;
          if (m_dig == 3) begin m_mode = 0; m_dig = 0; end
          else m_dig++;
        end else begin
          if (up) begin
            d = (m_val / pw10(m_dig)) % 10;
            m_val = m_val + (((d + 1) % 10) - d) * pw10(m_dig);
          end
          m_bage++;
        end
      end
      default: begin
        if (run) m_mode = 0;
        else begin
          m_age++;
          if (m_age % TP == 0) m_val = (m_val + 1) % 10000;
        end
      end
    endcase
  endtask

  task automatic check_model();
    logic [3:0] eb;
    eb = (m_mode == 1 && ((m_bage / HP) % 2) == 1) ? 4'(1 << m_dig) : 4'b0000;
    chk("model_value", VALUE, to_bcd(m_val));
    chk("model_blank", {12'h0, BLANK}, {12'h0, eb});
    chk("model_edit_dig", {14'h0, EDIT_DIG}, 16'(m_dig));
    chk("model_running", {15'h0, RUNNING}, {15'h0, m_mode == 2});
  endtask

  task automatic apply(input logic [2:0] b);
    @(negedge CLK);
    BIN = b;
    @(posedge CLK);
    model_step(b);
    #1;
    check_model();
  endtask

  task automatic idle(input int n);
    repeat (n) apply(3'b000);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_value"}, VALUE, 16'h0000);
    chk({tag, "_blank"}, {12'h0, BLANK}, 16'h0000);
    chk({tag, "_edit_dig"}, {14'h0, EDIT_DIG}, 16'h0000);
    chk({tag, "_running"}, {15'h0, RUNNING}, 16'h0000);
  endtask

  initial begin
    logic [2:0] b;
    int r;

    // Reset and quiet idle
    BIN  = 3'b000;
    nRST = 1'b0;
    model_reset();
    repeat (3) @(posedge CLK);
    #1;
    chk_reset_outputs("in_reset");
    @(negedge CLK);
    nRST = 1'b1;
    idle(100);
    chk_reset_outputs("after_idle100");

    // Edit sequence table: SEL, UP x3, SEL, UP x12, SEL x3
    tbl[0] = '{3'b001, 16'h0000, 4'b0000, 2'd0, 1'b0};
    for (int i = 1; i <= 3; i++) tbl[i] = '{3'b010, 16'(i), 4'b0000, 2'd0, 1'b0};
    tbl[4] = '{3'b001, 16'h0003, 4'b0000, 2'd1, 1'b0};
    for (int k = 1; k <= 12; k++)
      tbl[4+k] = '{3'b010, {8'h00, 4'(k % 10), 4'h3}, (k >= HP) ? 4'b0010 : 4'b0000, 2'd1, 1'b0};
    tbl[17] = '{3'b001, 16'h0023, 4'b0000, 2'd2, 1'b0};
    tbl[18] = '{3'b001, 16'h0023, 4'b0000, 2'd3, 1'b0};
    tbl[19] = '{3'b001, 16'h0023, 4'b0000, 2'd0, 1'b0};
    for (int i = 0; i < 20; i++) begin
      apply(tbl[i].bin);
      chk($sformatf("tbl%0d_value", i), VALUE, tbl[i].value);
      chk($sformatf("tbl%0d_blank", i), {12'h0, BLANK}, {12'h0, tbl[i].blank});
      chk($sformatf("tbl%0d_dig", i), {14'h0, EDIT_DIG}, {14'h0, tbl[i].dig});
      chk($sformatf("tbl%0d_run", i), {15'h0, RUNNING}, {15'h0, tbl[i].run});
    end

    // Count and stop
    apply(3'b010);
    chk("clear_in_idle", VALUE, 16'h0000);
    apply(3'b100);
    chk("run_entry", {15'h0, RUNNING}, 16'h0001);
    idle(9);
    chk("run_before_tick", VALUE, 16'h0000);
    idle(1);
    chk("run_tick1", VALUE, 16'h0001);
    idle(10);
    chk("run_tick2", VALUE, 16'h0002);
    idle(4);
    apply(3'b100);
    chk("stop_value", VALUE, 16'h0002);
    chk("stop_running", {15'h0, RUNNING}, 16'h0000);
    idle(15);
    chk("frozen_value", VALUE, 16'h0002);

    // Blink on digit 2, SEL mid-dark restarts lit phase on digit 3
    apply(3'b001);
    apply(3'b001);
    apply(3'b001);
    chk("blink_sel_edge", {12'h0, BLANK}, 16'h0000);
    for (int k = 1; k < HP; k++) begin
      apply(3'b000);
      chk("blink_lit2", {12'h0, BLANK}, 16'h0000);
    end
    for (int k = 0; k < 5; k++) begin
      apply(3'b000);
      chk("blink_dark2", {12'h0, BLANK}, 16'h0004);
    end
    apply(3'b001);
    chk("blink_sel_dig3", {14'h0, EDIT_DIG}, 16'h0003);
    chk("blink_restart", {12'h0, BLANK}, 16'h0000);
    for (int k = 1; k < HP; k++) begin
      apply(3'b000);
      chk("blink_lit3", {12'h0, BLANK}, 16'h0000);
    end
    for (int k = 0; k < HP; k++) begin
      apply(3'b000);
      chk("blink_dark3", {12'h0, BLANK}, 16'h0008);
    end
    apply(3'b001);
    chk("blink_exit_blank", {12'h0, BLANK}, 16'h0000);

    // Preload 9998 and wrap through 0000
    apply(3'b010);
    apply(3'b001);
    repeat (8) apply(3'b010);
    for (int d = 1; d < 4; d++) begin
      apply(3'b001);
      repeat (9) apply(3'b010);
    end
    apply(3'b001);
    chk("preload", VALUE, 16'h9998);
    chk("preload_idle", {15'h0, RUNNING}, 16'h0000);
    apply(3'b100);
    idle(20);
    chk("wrap_value", VALUE, 16'h0000);
    chk("wrap_running", {15'h0, RUNNING}, 16'h0001);
    idle(11);
    chk("post_wrap", VALUE, 16'h0001);
    apply(3'b111);
    chk("combo_value", VALUE, 16'h0001);
    chk("combo_running", {15'h0, RUNNING}, 16'h0000);
    chk("combo_dig", {14'h0, EDIT_DIG}, 16'h0000);
    apply(3'b010);
    chk("combo_left_idle", VALUE, 16'h0000);

    // Asynchronous reset mid-count
    apply(3'b100);
    idle(5 * TP);
    chk("pre_reset_value", VALUE, 16'h0005);
    @(posedge CLK);
    #3;
    nRST = 1'b0;
    #1;
    chk_reset_outputs("async_reset");
    model_reset();
    @(posedge CLK);
    #1;
    chk_reset_outputs("held_reset");
    @(negedge CLK);
    nRST = 1'b1;
    apply(3'b010);
    chk("up_after_reset", VALUE, 16'h0000);
    chk("idle_after_reset", {15'h0, RUNNING}, 16'h0000);

    // Random pulses against the model
    for (int i = 0; i < 3000; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 2)       b = 3'b100;
      else if (r < 10) b = 3'b001;
      else if (r < 20) b = 3'b010;
      else if (r < 22) b = 3'($urandom_range(0, 7));
      else             b = 3'b000;
      apply(b);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/btn_seq_ctrl.md
# btn_seq_ctrl

Three-button command sequencer for the seg7dec board design. Consumes the one-cycle, debounced press pulses from the button input stage and drives a 4-digit BCD value plus per-digit blank mask to the 7-segment decoders. Modes: idle/hold, digit edit with blinking cursor, and free-running count.

## Interface
- CLK_HZ, default 50_000_000: CLK frequency; must be divisible by TICK_HZ and by 2*BLINK_HZ.
- TICK_HZ, default 10: count rate in RUN.
- BLINK_HZ, default 2: cursor blink rate in EDIT; 50 % duty.
- CLK  in  1  system clock; all logic on rising edge.
- nRST  in  1  asynchronous, active-low reset.
- BIN  in  3  one-cycle press pulses, active high: bit0 SEL, bit1 UP, bit2 RUN.
- VALUE  out  16  four BCD digits; [3:0] digit 0 (rightmost).
- BLANK  out  4  per-digit blank request to decoders; 1 = digit dark.
- EDIT_DIG  out  2  digit index under edit; 0 outside EDIT.
- RUNNING  out  1  high while in RUN.

## Operation
- States: IDLE, EDIT, RUN. Reset: IDLE, VALUE=16'h0000, BLANK=4'b0000, EDIT_DIG=0, RUNNING=0.
- Multiple BIN bits in one cycle: priority RUN > SEL > UP; lower-priority bits that cycle are dropped.
- IDLE: RUN -> RUN. SEL -> EDIT, EDIT_DIG=0. UP -> VALUE cleared to 0000, stays IDLE.
- EDIT: UP -> selected digit +1 mod 10 (9 -> 0, no carry into neighbour). SEL -> EDIT_DIG+1; SEL at EDIT_DIG=3 -> IDLE, EDIT_DIG=0. RUN -> RUN, EDIT_DIG=0, value kept.
- RUN: each tick, VALUE += 1 in BCD with ripple carry; 9999 -> 0000 wrap, keep running. RUN -> IDLE, value frozen. SEL and UP ignored.
- BLANK: zero outside EDIT. In EDIT, bit EDIT_DIG high during the dark half of the blink period, other bits 0.
- Digits of VALUE are always valid BCD (0-9); no state produces A-F.
- nRST low at any time, including mid-count or mid-edit, returns to reset values asynchronously; no pulse is remembered across reset.

## Timing
- All outputs registered. BIN pulse sampled at edge n: state, VALUE, EDIT_DIG, RUNNING, BLANK reflect it after edge n.
- Tick divider: period TP = CLK_HZ/TICK_HZ cycles; cleared on RUN entry, so first increment occurs exactly TP cycles after the entry edge, then every TP cycles. A RUN pulse coinciding with a tick stops without applying that increment.
- Blink divider: half-period HP = CLK_HZ/(2*BLINK_HZ). Cleared on EDIT entry and on every SEL within EDIT; the selected digit is lit for the first HP cycles, dark for the next HP, repeating. UP does not restart blink.
- Dividers hold at zero outside their active state.

## Structure
- Package btn_seq_pkg: state enum (IDLE, EDIT, RUN), BIN bit index constants (B_SEL=0, B_UP=1, B_RUN=2), BCD digit width constant (4).
- Sub-module tick_gen (parameter DIV, inputs CLK, nRST, CLR; output one-cycle TICK every DIV cycles), instantiated twice: count tick (DIV=TP) and blink toggle (DIV=HP).
- Top holds FSM, BCD incrementer (per-digit mod-10 with carry chain), blink phase flop, output registers.

## Test plan
Use CLK_HZ=100, TICK_HZ=10 (TP=10), BLINK_HZ=5 (HP=10).
- Reset then no input for 100 cycles -> VALUE=0000, BLANK=0000, RUNNING=0 throughout.
- RUN pulse at edge n -> RUNNING=1 after n; VALUE=0001 after n+10, 0002 after n+20; RUN pulse at n+25 -> IDLE, VALUE stays 0002.
- SEL, UP x3, SEL, UP x12, SEL, SEL, SEL -> VALUE=0023 (digit1 wraps after 9 -> 12 presses give 2), back in IDLE, EDIT_DIG=0, BLANK=0.
- In EDIT at digit 2 -> BLANK=4'b0000 for 10 cycles, 4'b0100 for 10 cycles, repeating; SEL mid-dark -> digit 3 lit immediately for 10 cycles.
- Preload 9998 via EDIT, RUN -> after 20 cycles VALUE=0000, RUNNING still 1; RUN+SEL+UP in one cycle -> only stop applied.
- Assert nRST mid-RUN at VALUE=0005 -> all outputs reset values asynchronously; after release, UP pulse in IDLE leaves VALUE=0000.
